wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter N, default 2, number of Wishbone masters (legal range 2..4).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; select width DW/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, max wait cycles for slave ack/err; 0 disables the watchdog.
REQ-005 SHALL have port clk_in  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset_in  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports m_cyc_in, m_stb_in, m_we_in  input  N  per-master cycle, strobe, write enable.
REQ-008 SHALL have ports m_adr_in  input  N x AW, m_dat_in  input  N x DW, m_sel_in  input  N x DW/8, per-master request fields.
REQ-009 SHALL have ports m_ack_out, m_err_out  output  N  per-master acknowledge and error.
REQ-010 SHALL have port m_dat_out  output  DW  slave read data, broadcast to all masters.
REQ-011 SHALL have ports s_cyc_out, s_stb_out, s_we_out  output  1; s_adr_out  output  AW; s_dat_out  output  DW; s_sel_out  output  DW/8; shared slave-side request.
REQ-012 SHALL have ports s_ack_in, s_err_in  input  1; s_dat_in  input  DW; slave response.
REQ-013 SHALL have port grant_out  output  N  one-hot current owner; all-zero when idle.
REQ-014 SHALL have port timeout_out  output  1  one-cycle pulse when the watchdog fires.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and ABORT.
REQ-016 IDLE: on a clock edge with any m_cyc_in high, SHALL register a grant and enter BUSY; arbitration latency is one cycle.
REQ-017 Arbitration SHALL be round-robin: search starts at index last_grant+1 modulo N; the first master with cyc high wins.
REQ-018 BUSY: s_cyc_out, s_stb_out, s_we_out, s_adr_out, s_dat_out and s_sel_out SHALL combinationally follow the granted master's inputs; s_cyc_out = m_cyc_in[grant].
REQ-019 BUSY: s_ack_in and s_err_in SHALL route combinationally to the granted master only; every other m_ack_out and m_err_out SHALL be 0.
REQ-020 Grant SHALL be held for the whole cycle, including multi-beat bursts, until the granted master's m_cyc_in is sampled low.
REQ-021 The edge that samples the granted m_cyc_in low SHALL update last_grant to the grant, enter IDLE, and clear grant_out; re-arbitration follows on the next edge.
REQ-022 Requests from non-granted masters SHALL never reach the slave and SHALL not alter the current grant.
REQ-023 Watchdog: in BUSY, a counter SHALL increment each cycle where s_stb_out=1 and s_ack_in=0 and s_err_in=0.
REQ-024 The counter SHALL clear on ack, on err, on stb low, and on entry to BUSY.
REQ-025 When the counter reaches TIMEOUT (TIMEOUT>0), the next state SHALL be ABORT.
REQ-026 On ABORT entry, m_err_out[grant]=1 for exactly one cycle and timeout_out=1 for that same cycle.
REQ-027 In ABORT, s_cyc_out and s_stb_out SHALL be 0 and slave ack/err SHALL be ignored.
REQ-028 ABORT SHALL return to IDLE once the granted m_cyc_in is sampled low, updating last_grant as in REQ-021.
REQ-029 If s_ack_in arrives on the same cycle the counter hits TIMEOUT, the ack SHALL win: it is delivered to the master and no abort occurs.
REQ-030 In IDLE, all slave-side outputs, m_ack_out and m_err_out SHALL be 0.
REQ-031 The counter SHALL saturate and never wrap; its width SHALL be clog2(TIMEOUT+1), minimum 1.

Reset
REQ-032 On reset_in low, asynchronously and immediately: state IDLE; grant_out 0; counter 0; timeout_out 0; last_grant N-1 (so master 0 has first priority); all s_* and m_ack/m_err outputs 0.
REQ-033 Reset asserted mid-transfer SHALL drop s_cyc_out in the same cycle; no ack is forwarded after reset asserts.
REQ-034 After reset_in is released, the first arbitration SHALL occur on the first rising edge at which reset_in is high.

Verification
REQ-035 Masters 0 and 1 raise cyc together after reset -> grant_out=01 one cycle later; master 0 single read, slave ack with s_dat_in=0xDEADBEEF -> m_ack_out=01 and m_dat_out=0xDEADBEEF; master 0 drops cyc -> IDLE, then grant_out=10.
REQ-036 Both masters continuously request with 4 single-beat cycles each -> grants alternate 0,1,0,1,...; no master is granted twice in a row.
REQ-037 Master 1 holds cyc for a 4-beat write burst while master 0 requests -> grant_out stays 10 for all 4 acks; m_ack_out[0] stays 0.
REQ-038 TIMEOUT=8, slave never acks -> after 8 stalled cycles m_err_out[grant]=1 and timeout_out=1 for 1 cycle; s_cyc_out=0 until master drops cyc; then IDLE.
REQ-039 TIMEOUT=8, ack on the 8th stalled cycle -> ack delivered and no err/timeout pulse; reset_in pulsed low mid-BUSY -> s_cyc_out=0 and grant_out=0 immediately, then master 0 wins the next arbitration.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, with a stall watchdog
// that aborts a cycle the slave never answers.
module wb_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic [N-1:0]              m_cyc_in,
    input  logic [N-1:0]              m_stb_in,
    input  logic [N-1:0]              m_we_in,
    input  logic [N-1:0][AW-1:0]      m_adr_in,
    input  logic [N-1:0][DW-1:0]      m_dat_in,
    input  logic [N-1:0][DW/8-1:0]    m_sel_in,
    output logic [N-1:0]              m_ack_out,
    output logic [N-1:0]              m_err_out,
    output logic [DW-1:0]             m_dat_out,
    output logic                      s_cyc_out,
    output logic                      s_stb_out,
    output logic                      s_we_out,
    output logic [AW-1:0]             s_adr_out,
    output logic [DW-1:0]             s_dat_out,
    output logic [DW/8-1:0]           s_sel_out,
    input  logic                      s_ack_in,
    input  logic                      s_err_in,
    input  logic [DW-1:0]             s_dat_in,
    output logic [N-1:0]              grant_out,
    output logic                      timeout_out
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t          state;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   cand;
    logic            arb_found;
    logic [CW-1:0]   wd_cnt;
    logic [CW-1:0]   wd_next;
    logic            stall;
    logic            wd_hit;

    // Round-robin search: first requester after last_grant, wrapping modulo N.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_grant;
        cand      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(last_grant) + i) % N);
            if (!arb_found && m_cyc_in[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign stall   = (state == BUSY) && s_stb_out && !s_ack_in && !s_err_in;
    assign wd_next = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;
    assign wd_hit  = (TIMEOUT != 0) && (32'(wd_next) >= TIMEOUT);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state       <= IDLE;
            grant_out   <= '0;
            gidx        <= '0;
            last_grant  <= IW'(N - 1);
            wd_cnt      <= '0;
            timeout_out <= 1'b0;
        end else begin
            timeout_out <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (arb_found) begin
                        state              <= BUSY;
                        gidx               <= arb_idx;
                        grant_out          <= '0;
                        grant_out[arb_idx] <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!m_cyc_in[gidx]) begin
                        state      <= IDLE;
                        last_grant <= gidx;
                        grant_out  <= '0;
                        wd_cnt     <= '0;
                    end else if (stall) begin
                        wd_cnt <= wd_next;
                        if (wd_hit) begin
                            state       <= ABORT;
                            timeout_out <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                ABORT: begin
                    if (!m_cyc_in[gidx]) begin
                        state      <= IDLE;
                        last_grant <= gidx;
                        grant_out  <= '0;
                        wd_cnt     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave side only sees the owner while BUSY; ABORT and IDLE keep the bus quiet.
    always_comb begin
        s_cyc_out = 1'b0;
        s_stb_out = 1'b0;
        s_we_out  = 1'b0;
        s_adr_out = '0;
        s_dat_out = '0;
        s_sel_out = '0;
        m_ack_out = '0;
        m_err_out = '0;
        m_dat_out = s_dat_in;
        if (state == BUSY) begin
            s_cyc_out       = m_cyc_in[gidx];
            s_stb_out       = m_stb_in[gidx];
            s_we_out        = m_we_in[gidx];
            s_adr_out       = m_adr_in[gidx];
            s_dat_out       = m_dat_in[gidx];
            s_sel_out       = m_sel_in[gidx];
            m_ack_out[gidx] = s_ack_in;
            m_err_out[gidx] = s_err_in;
        end
        if (state == ABORT && timeout_out) begin
            m_err_out = grant_out;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (N=2, TIMEOUT=8) with a transaction-level
// ownership model checked against the DUT on every falling clock edge.
module tb_wb_arbiter;

    localparam int N   = 2;
    localparam int TMO = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N-1:0][31:0]  m_adr = '0, m_dat = '0;
    logic [N-1:0][3:0]   m_sel = '0;
    logic [N-1:0]        m_ack, m_err, grant;
    logic [31:0]         m_rdat, s_adr, s_wdat, s_rdat = '0;
    logic [3:0]          s_sel;
    logic                s_cyc, s_stb, s_we, s_ack = 1'b0, s_err = 1'b0, tmo;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    wb_arbiter #(.N(N), .AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk_in(clk), .reset_in(rst_n),
        .m_cyc_in(m_cyc), .m_stb_in(m_stb), .m_we_in(m_we),
        .m_adr_in(m_adr), .m_dat_in(m_dat), .m_sel_in(m_sel),
        .m_ack_out(m_ack), .m_err_out(m_err), .m_dat_out(m_rdat),
        .s_cyc_out(s_cyc), .s_stb_out(s_stb), .s_we_out(s_we),
        .s_adr_out(s_adr), .s_dat_out(s_wdat), .s_sel_out(s_sel),
        .s_ack_in(s_ack), .s_err_in(s_err), .s_dat_in(s_rdat),
        .grant_out(grant), .timeout_out(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the bus (-1 = nobody), who owned it last, how long the
    // current owner has waited, and whether its cycle has been aborted.
    int md_owner = -1, md_last = N - 1, md_wait = 0;
    bit md_abort = 1'b0, md_pulse = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int o, l, w, c;
        bit a, p;
        if (!rst_n) begin
            md_owner <= -1; md_last <= N - 1; md_wait <= 0;
            md_abort <= 1'b0; md_pulse <= 1'b0;
        end else begin
            o = md_owner; l = md_last; w = md_wait; a = md_abort; p = 1'b0;
            if (o < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (l + k) % N;
                    if (o < 0 && m_cyc[c]) begin
                        o = c; w = 0; a = 1'b0;
                    end
                end
            end else if (!m_cyc[o]) begin
                l = o; o = -1; a = 1'b0;
            end else if (!a) begin
                if (m_stb[o] && !s_ack && !s_err) begin
                    w++;
                    if (w == TMO) begin a = 1'b1; p = 1'b1; end
                end else begin
                    w = 0;
                end
            end
            md_owner <= o; md_last <= l; md_wait <= w; md_abort <= a; md_pulse <= p;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg, eack, eerr;
        logic ecyc, estb, ewe;
        logic [31:0] eadr, edat;
        logic [3:0] esel;
        if (run_chk) begin
            eg = '0; eack = '0; eerr = '0;
            ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; eadr = '0; edat = '0; esel = '0;
            if (md_owner >= 0) begin
                eg[md_owner] = 1'b1;
                if (!md_abort) begin
                    ecyc = m_cyc[md_owner]; estb = m_stb[md_owner]; ewe = m_we[md_owner];
                    eadr = m_adr[md_owner]; edat = m_dat[md_owner]; esel = m_sel[md_owner];
                    eack[md_owner] = s_ack;
                    eerr[md_owner] = s_err;
                end
                if (md_pulse) eerr[md_owner] = 1'b1;
            end
            chk("cmp_grant", grant, eg);
            chk("cmp_s_cyc", s_cyc, ecyc);
            chk("cmp_s_stb", s_stb, estb);
            chk("cmp_s_we", s_we, ewe);
            chk("cmp_s_adr", s_adr, eadr);
            chk("cmp_s_dat", s_wdat, edat);
            chk("cmp_s_sel", s_sel, esel);
            chk("cmp_m_ack", m_ack, eack);
            chk("cmp_m_err", m_err, eerr);
            chk("cmp_m_dat", m_rdat, s_rdat);
            chk("cmp_timeout", tmo, md_pulse);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int rem [N];
        int g;
        logic [N-1:0] expg;

        m_adr[0] = 32'h100; m_adr[1] = 32'h200;
        m_dat[0] = 32'hA0A0_0000; m_dat[1] = 32'hB1B1_0000;
        m_sel[0] = 4'hF; m_sel[1] = 4'h3;
        tick(); tick();
        run_chk = 1'b1;
        chk("reset_grant", grant, 2'b00);
        chk("reset_s_cyc", s_cyc, 1'b0);
        chk("reset_timeout", tmo, 1'b0);

        // Both masters request as reset releases; master 0 has first priority.
        rst_n = 1'b1;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        chk("first_grant", grant, 2'b01);
        chk("model_owner", md_owner, 0);
        chk("first_s_adr", s_adr, 32'h100);
        s_ack = 1'b1; s_rdat = 32'hDEADBEEF;
        #1;
        chk("read_ack", m_ack, 2'b01);
        chk("read_data", m_rdat, 32'hDEADBEEF);
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        chk("idle_after_drop", grant, 2'b00);
        tick();
        chk("second_grant", grant, 2'b10);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();

        // Four single-beat cycles per master; grants must alternate 0,1,0,1...
        rem[0] = 4; rem[1] = 4;
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int t = 0; t < 8; t++) begin
            for (int n = 0; n < 10 && grant == '0; n++) tick();
            expg = '0;
            expg[t % 2] = 1'b1;
            chk("rr_grant", grant, expg);
            g = grant[1] ? 1 : 0;
            s_ack = 1'b1; s_rdat = 32'(t);
            tick();
            s_ack = 1'b0; m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
            rem[g]--;
            tick();
            if (rem[g] > 0) begin m_cyc[g] = 1'b1; m_stb[g] = 1'b1; end
        end
        chk("model_last_rr", md_last, 1);

        // Master 1 burst of 4 writes while master 0 waits.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        tick();
        chk("burst_grant", grant, 2'b10);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_adr[1] = 32'h300 + 32'(4 * b);
            s_ack = 1'b1;
            #1;
            chk("burst_hold", grant, 2'b10);
            chk("burst_ack", m_ack, 2'b10);
            chk("burst_adr", s_adr, 32'h300 + 32'(4 * b));
            tick();
        end
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
        tick();
        chk("burst_release", grant, 2'b00);
        tick();
        chk("after_burst_grant", grant, 2'b01);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();

        // Slave never answers master 0: abort after 8 stalled cycles.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        chk("wd_grant", grant, 2'b01);
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("wd_no_early_timeout", tmo, 1'b0);
        end
        tick();
        chk("wd_timeout", tmo, 1'b1);
        chk("wd_err", m_err, 2'b01);
        chk("wd_s_cyc_low", s_cyc, 1'b0);
        chk("model_abort", md_abort, 1'b1);
        s_ack = 1'b1;
        #1;
        chk("abort_ignores_ack", m_ack, 2'b00);
        tick();
        chk("wd_pulse_one_cycle", tmo, 1'b0);
        chk("abort_err_cleared", m_err, 2'b00);
        chk("abort_holds_grant", grant, 2'b01);
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        chk("abort_to_idle", grant, 2'b00);

        // Ack on the 8th stalled cycle wins; counter restarts afterwards.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        chk("late_grant", grant, 2'b10);
        for (int i = 1; i < TMO; i++) tick();
        s_ack = 1'b1;
        #1;
        chk("late_ack", m_ack, 2'b10);
        tick();
        s_ack = 1'b0;
        chk("late_no_timeout", tmo, 1'b0);
        chk("late_no_err", m_err, 2'b00);
        chk("late_still_busy", s_cyc, 1'b1);
        for (int i = 1; i < TMO; i++) tick();
        chk("counter_cleared", tmo, 1'b0);

        // Reset mid-BUSY drops the bus immediately; master 0 wins afterwards.
        s_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_no_ack", m_ack, 2'b00);
        s_ack = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant", grant, 2'b01);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        tick(); tick();

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
